// File: rtl/ddr_read_prefetch_buf.sv
// ddr_read_prefetch_buf: credit-based DDR burst prefetch FIFO with wide-to-narrow playback serialiser
module ddr_read_prefetch_buf #(
  parameter int IN_W = 128,
  parameter int OUT_W = 32,
  parameter int DEPTH = 64,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUT = 2,
  parameter int START_LEVEL = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctrl_rd_en,
  input  logic [AW:0]      prog_thresh,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             ddr_req,
  input  logic             ddr_req_ack,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      level,
  output logic [AW:0]      outstanding,
  output logic             underrun,
  output logic             overflow
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int LW = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam logic [AW+1:0] D2 = (AW+2)'(DEPTH);
  localparam logic [AW+1:0] B2 = (AW+2)'(BURST_LEN);
  localparam logic [AW+1:0] M2 = (AW+2)'(MAX_OUT * BURST_LEN);
  localparam logic [AW+1:0] S2 = (AW+2)'(START_LEVEL);
  localparam logic [1:0] IDLE = 2'd0, PRIME = 2'd1, PLAY = 2'd2;

  logic [IN_W-1:0]  r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic [AW+1:0]    r_out;
  logic             r_req, r_ovalid, r_last, r_under, r_over;
  logic [OUT_W-1:0] r_odata;
  logic [LW-1:0]    r_lane;
  logic [1:0]       r_state;

  logic [AW:0]      w_level, w_base;
  logic [AW+1:0]    w_resv, w_osum, w_onext;
  logic             w_wr, w_ack, w_acc, w_pop, w_avail, w_load, w_req_set;
  logic [1:0]       w_nstate;
  logic [IN_W-1:0]  w_word;
  logic [OUT_W-1:0] w_lanes [RATIO];

  assign w_level = r_wptr - r_rptr;
  assign w_wr = in_valid && {1'b0, w_level} < D2;
  assign w_ack = r_req && ddr_req_ack;
  assign w_resv = {1'b0, w_level} + r_out;
  assign w_req_set = ctrl_rd_en && w_resv < {1'b0, prog_thresh} && w_resv + B2 <= D2 && r_out < M2;
  assign w_osum = r_out + (w_ack ? B2 : '0);
  assign w_onext = (w_wr && w_osum != '0) ? w_osum - 1'b1 : w_osum;

  // While the last lane of a word sits in the output register, the next load comes from the following word
  assign w_acc = r_ovalid && out_ready;
  assign w_pop = w_acc && r_last;
  assign w_base = r_rptr + {{AW{1'b0}}, r_ovalid && r_last};
  assign w_avail = r_wptr != w_base;
  assign w_load = r_state == PLAY && ctrl_rd_en && (!r_ovalid || out_ready) && w_avail;
  assign w_word = r_mem[w_base[AW-1:0]];

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign w_lanes[i] = w_word[i*OUT_W +: OUT_W];
  end

  assign w_nstate = r_state == IDLE  ? (ctrl_rd_en ? PRIME : IDLE)
                  : r_state == PRIME ? (!ctrl_rd_en ? IDLE : {1'b0, w_level} >= S2 ? PLAY : PRIME)
                  : (!ctrl_rd_en && (!r_ovalid || out_ready)) ? IDLE : PLAY;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_out <= '0;
      r_req <= 1'b0;
      r_ovalid <= 1'b0;
      r_last <= 1'b0;
      r_odata <= '0;
      r_lane <= '0;
      r_state <= IDLE;
      r_under <= 1'b0;
      r_over <= 1'b0;
    end else begin
      r_wptr <= r_wptr + {{AW{1'b0}}, w_wr};
      r_rptr <= r_rptr + {{AW{1'b0}}, w_pop};
      r_out <= w_onext;
      r_req <= r_req ? !w_ack : w_req_set;
      r_state <= w_nstate;
      r_over <= r_over | (in_valid && !w_wr);
      r_under <= r_under | (r_state == PLAY && out_ready && !r_ovalid && !w_avail);
      if (w_load) begin
        r_odata <= w_lanes[r_lane];
        r_ovalid <= 1'b1;
        r_last <= r_lane == LW'(RATIO - 1);
        r_lane <= r_lane == LW'(RATIO - 1) ? '0 : r_lane + 1'b1;
      end else if (w_acc) begin
        r_ovalid <= 1'b0;
      end
    end
  end

  assign ddr_req = r_req;
  assign out_data = r_odata;
  assign out_valid = r_ovalid;
  assign level = w_level;
  assign outstanding = r_out[AW:0];
  assign underrun = r_under;
  assign overflow = r_over;
endmodule

// File: tb/tb_ddr_read_prefetch_buf.sv
// tb_ddr_read_prefetch_buf: randomized scenarios checked against a queue-based model of the prefetch buffer
module tb_ddr_read_prefetch_buf;
  localparam int IN_W = 128, OUT_W = 32, DEPTH = 64, BL = 16, MO = 2, RATIO = 4, AW = 6;

  logic clk = 1'b0, rst = 1'b1, ctrl_rd_en = 1'b0, in_valid = 1'b0, ddr_req_ack = 1'b0, out_ready = 1'b0;
  logic [AW:0] prog_thresh = '0;
  logic [IN_W-1:0] in_data = '0;
  logic ddr_req, out_valid, underrun, overflow;
  logic [OUT_W-1:0] out_data;
  logic [AW:0] level, outstanding;

  int n_cmp = 0, n_err = 0;
  logic [IN_W-1:0] mq[$];
  logic [OUT_W-1:0] exp_s[$], got[$];
  int mo, mlane;
  bit mreq, mov;

  ddr_read_prefetch_buf dut (
    .clk(clk), .rst(rst), .ctrl_rd_en(ctrl_rd_en), .prog_thresh(prog_thresh),
    .in_data(in_data), .in_valid(in_valid), .ddr_req(ddr_req), .ddr_req_ack(ddr_req_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .outstanding(outstanding), .underrun(underrun), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Collect every accepted sample; retire a stored word once its last lane is taken
  always @(posedge clk) begin
    if (rst) mlane = 0;
    else if (out_valid && out_ready) begin
      got.push_back(out_data);
      if (mlane == RATIO - 1) begin
        mlane = 0;
        if (mq.size() > 0) mq.delete(0);
      end else mlane++;
    end
  end

  function automatic logic [IN_W-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drive one cycle's inputs, apply the buffer's rules to the model, then wait for the next negedge
  task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic a);
    int res;
    bit w;
    in_valid = v; in_data = d; ddr_req_ack = a;
    res = mq.size() + mo;
    w = v && mq.size() < DEPTH;
    if (v && !w) mov = 1;
    if (mreq) begin
      if (a) begin mreq = 0; mo += BL; end
    end else if (ctrl_rd_en && res < int'(prog_thresh) && res + BL <= DEPTH && mo < MO * BL) mreq = 1;
    if (w) begin
      if (mo > 0) mo--;
      mq.push_back(d);
      for (int i = 0; i < RATIO; i++) exp_s.push_back(d[i*OUT_W +: OUT_W]);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; ddr_req_ack = 0; ctrl_rd_en = 0; out_ready = 0; prog_thresh = '0;
    @(negedge clk);
    @(negedge clk);
    mq.delete(); exp_s.delete(); got.delete(); mo = 0; mreq = 0; mov = 0;
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    ctrl_rd_en = 1; prog_thresh = 7'd48; out_ready = 1;
    cyc(0, '0, 0);
    cyc(0, '0, 1);
    for (int i = 0; i < 3; i++) cyc(1, rnd_word(), 0);
    do_reset();
    n_cmp++; if (ddr_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %0b exp 0", ddr_req); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b exp 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data got %0h exp 0", out_data); end
    n_cmp++; if (level !== 7'd0) begin n_err++; $display("FAIL rst_level got %0d exp 0", level); end
    n_cmp++; if (outstanding !== 7'd0) begin n_err++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_underrun got %0b exp 0", underrun); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_overflow got %0b exp 0", overflow); end
    cyc(1, rnd_word(), 0);
    n_cmp++; if (level !== 7'd1) begin n_err++; $display("FAIL late_beat_level got %0d exp 1", level); end
    n_cmp++; if (outstanding !== 7'd0) begin n_err++; $display("FAIL late_beat_outstanding got %0d exp 0", outstanding); end
  endtask

  task automatic test_credit_play();
    do_reset();
    ctrl_rd_en = 1; prog_thresh = 7'd48;
    cyc(0, '0, 0);
    n_cmp++; if (ddr_req !== 1'b1) begin n_err++; $display("FAIL req_first got %0b exp 1", ddr_req); end
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    n_cmp++; if (ddr_req !== 1'b1) begin n_err++; $display("FAIL req_held got %0b exp 1", ddr_req); end
    cyc(0, '0, 1);
    n_cmp++; if (ddr_req !== 1'b0) begin n_err++; $display("FAIL req_drop got %0b exp 0", ddr_req); end
    n_cmp++; if (outstanding !== 7'd16) begin n_err++; $display("FAIL ack1_outstanding got %0d exp 16", outstanding); end
    cyc(0, '0, 0);
    n_cmp++; if (ddr_req !== 1'b1) begin n_err++; $display("FAIL req_second got %0b exp 1", ddr_req); end
    cyc(0, '0, 1);
    n_cmp++; if (outstanding !== 7'd32) begin n_err++; $display("FAIL ack2_outstanding got %0d exp 32", outstanding); end
    for (int i = 0; i < 4; i++) begin
      cyc(0, '0, 0);
      n_cmp++; if (ddr_req !== 1'b0) begin n_err++; $display("FAIL max_out_req cyc %0d got %0b exp 0", i, ddr_req); end
    end
    for (int i = 0; i < 32; i++) begin
      cyc(1, rnd_word(), 0);
      n_cmp++; if (ddr_req !== mreq || outstanding !== 7'(mo)) begin
        n_err++; $display("FAIL deliver beat %0d req %0b/%0b outstanding %0d/%0d", i, ddr_req, mreq, outstanding, mo);
      end
    end
    n_cmp++; if (level !== 7'd32) begin n_err++; $display("FAIL fill_level got %0d exp 32", level); end
    n_cmp++; if (outstanding !== 7'd0) begin n_err++; $display("FAIL fill_outstanding got %0d exp 0", outstanding); end
    cyc(0, '0, 0);
    cyc(0, '0, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL play_entry_valid got %0b exp 1", out_valid); end
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      cyc(0, '0, 0);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL gap_free cyc %0d got %0b exp 1", i, out_valid); end
    end
    n_cmp++; if (got.size() != 8) begin n_err++; $display("FAIL play_count got %0d exp 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (got[i] !== exp_s[i]) begin n_err++; $display("FAIL play_data %0d got %0h exp %0h", i, got[i], exp_s[i]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 64; i++) cyc(1, rnd_word(), 0);
    n_cmp++; if (level !== 7'd64) begin n_err++; $display("FAIL full_level got %0d exp 64", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_overflow got %0b exp 0", overflow); end
    cyc(1, rnd_word(), 0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_flag got %0b exp 1", overflow); end
    n_cmp++; if (level !== 7'd64) begin n_err++; $display("FAIL overflow_level got %0d exp 64", level); end
    ctrl_rd_en = 1; out_ready = 1;
    for (int i = 0; i < 270; i++) cyc(0, '0, 0);
    n_cmp++; if (got.size() != 256) begin n_err++; $display("FAIL drain_count got %0d exp 256", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp_s[i]) begin n_err++; $display("FAIL drain_data %0d got %0h exp %0h", i, got[i], exp_s[i]); end
    end
  endtask

  task automatic test_underrun();
    int n0, k;
    do_reset();
    ctrl_rd_en = 1;
    for (int i = 0; i < 32; i++) cyc(1, rnd_word(), 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 0);
    out_ready = 1;
    k = 0;
    while (level !== 7'd1 && k < 200) begin cyc(0, '0, 0); k++; end
    n_cmp++; if (k >= 200) begin n_err++; $display("FAIL reach_level1 got %0d exp 1", level); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL early_underrun got %0b exp 0", underrun); end
    n0 = got.size();
    k = 0;
    while (out_valid === 1'b1 && k < 10) begin cyc(0, '0, 0); k++; end
    n_cmp++; if (got.size() - n0 != 4) begin n_err++; $display("FAIL last_word_samples got %0d exp 4", got.size() - n0); end
    n_cmp++; if (level !== 7'd0) begin n_err++; $display("FAIL empty_level got %0d exp 0", level); end
    cyc(0, '0, 0);
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_flag got %0b exp 1", underrun); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL underrun_valid got %0b exp 0", out_valid); end
    cyc(1, rnd_word(), 0);
    cyc(0, '0, 0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL resume_valid got %0b exp 1", out_valid); end
    for (int i = 0; i < 6; i++) cyc(0, '0, 0);
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_sticky got %0b exp 1", underrun); end
    n_cmp++; if (got.size() != 132) begin n_err++; $display("FAIL resume_count got %0d exp 132", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp_s[i]) begin n_err++; $display("FAIL underrun_data %0d got %0h exp %0h", i, got[i], exp_s[i]); end
    end
  endtask

  task automatic test_collision();
    do_reset();
    ctrl_rd_en = 1; prog_thresh = 7'd48;
    cyc(0, '0, 0);
    cyc(0, '0, 1);
    for (int i = 0; i < 11; i++) cyc(1, rnd_word(), 0);
    n_cmp++; if (outstanding !== 7'd5) begin n_err++; $display("FAIL pre_collision_outstanding got %0d exp 5", outstanding); end
    n_cmp++; if (ddr_req !== 1'b1) begin n_err++; $display("FAIL pre_collision_req got %0b exp 1", ddr_req); end
    cyc(1, rnd_word(), 1);
    n_cmp++; if (outstanding !== 7'd20) begin n_err++; $display("FAIL collision_outstanding got %0d exp 20", outstanding); end
    n_cmp++; if (level !== 7'd12) begin n_err++; $display("FAIL collision_level got %0d exp 12", level); end
  endtask

  task automatic test_random_ready();
    logic pv, pr, a, v;
    logic [OUT_W-1:0] pd;
    int k;
    do_reset();
    ctrl_rd_en = 1; prog_thresh = 7'd48;
    k = 0;
    while (got.size() < 200 && k < 4000) begin
      pv = out_valid; pd = out_data;
      out_ready = 1'($urandom_range(0, 1)); pr = out_ready;
      a = ddr_req && ($urandom_range(0, 2) == 0);
      v = (mo > 0) && ($urandom_range(0, 3) != 0);
      cyc(v, rnd_word(), a);
      k++;
      n_cmp++; if (ddr_req !== mreq || outstanding !== 7'(mo) || level !== 7'(mq.size())) begin
        n_err++; $display("FAIL rand_state cyc %0d req %0b/%0b out %0d/%0d level %0d/%0d", k, ddr_req, mreq, outstanding, mo, level, mq.size());
      end
      if (pv && !pr) begin
        n_cmp++; if (out_valid !== 1'b1 || out_data !== pd) begin
          n_err++; $display("FAIL stall_hold cyc %0d got %0b/%0h exp 1/%0h", k, out_valid, out_data, pd);
        end
      end
    end
    n_cmp++; if (got.size() < 200) begin n_err++; $display("FAIL rand_samples got %0d exp 200", got.size()); end
    n_cmp++; if (overflow !== mov) begin n_err++; $display("FAIL rand_overflow got %0b exp %0b", overflow, mov); end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp_s[i]) begin n_err++; $display("FAIL rand_data %0d got %0h exp %0h", i, got[i], exp_s[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_credit_play();
    test_overflow();
    test_underrun();
    test_collision();
    test_random_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
